// File: rtl/data_mem_arbiter.sv
// Arbitrates the core (requester 0) and the loader (requester 1) onto one data memory port.
// The core has priority; the loader is forced through after MAX_WAIT refusals. Responses follow one cycle later.
module data_mem_arbiter #(
    parameter int unsigned     DATA_WIDTH    = 32,
    parameter longint unsigned START_ADDRESS = 32'h10000,
    parameter longint unsigned END_ADDRESS   = 32'h1FFFF,
    parameter int unsigned     MAX_WAIT      = 4,
    localparam int unsigned    WCW           = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic                  req0_we_i,
    input  logic                  req0_byte_i,
    input  logic [DATA_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wd_i,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_rd_o,
    output logic                  rsp0_err_o,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic                  req1_we_i,
    input  logic                  req1_byte_i,
    input  logic [DATA_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wd_i,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_rd_o,
    output logic                  rsp1_err_o,

    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,

    output logic [WCW-1:0]        dbg_wait_cnt_o
);

    localparam logic [DATA_WIDTH-1:0] L_START    = DATA_WIDTH'(START_ADDRESS);
    localparam logic [DATA_WIDTH-1:0] L_END      = DATA_WIDTH'(END_ADDRESS);
    localparam logic [DATA_WIDTH-1:0] L_WORD_END = DATA_WIDTH'(END_ADDRESS - 3);
    localparam logic [WCW-1:0]        L_MAX_WAIT = WCW'(MAX_WAIT);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // ready is combinational, never asserted without valid, and at most one ready is high.
    logic                  w_force1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic                  w_sel_we;
    logic                  w_sel_byte;
    logic [DATA_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wd;
    logic                  w_in_range;
    logic                  w_legal;
    logic                  w_load_ok;

    logic [WCW-1:0]        r_wait_cnt;
    logic                  r_rsp0_valid;
    logic                  r_rsp0_err;
    logic [DATA_WIDTH-1:0] r_rsp0_rd;
    logic                  r_rsp1_valid;
    logic                  r_rsp1_err;
    logic [DATA_WIDTH-1:0] r_rsp1_rd;

    assign w_force1 = (r_wait_cnt == L_MAX_WAIT);
    assign w_gnt1   = rst_ni & req1_valid_i & (~req0_valid_i | w_force1);
    assign w_gnt0   = rst_ni & req0_valid_i & ~w_gnt1;
    assign w_any    = w_gnt0 | w_gnt1;

    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_byte = 1'b0;
        w_sel_addr = '0;
        w_sel_wd   = '0;
        if (w_gnt0) begin
            w_sel_we   = req0_we_i;
            w_sel_byte = req0_byte_i;
            w_sel_addr = req0_addr_i;
            w_sel_wd   = req0_wd_i;
        end else if (w_gnt1) begin
            w_sel_we   = req1_we_i;
            w_sel_byte = req1_byte_i;
            w_sel_addr = req1_addr_i;
            w_sel_wd   = req1_wd_i;
        end
    end

    // Word accesses must be aligned and keep all four bytes inside the window.
    assign w_in_range = (w_sel_addr >= L_START) &&
                        (w_sel_byte ? (w_sel_addr <= L_END) : (w_sel_addr <= L_WORD_END));
    assign w_legal    = w_in_range && (w_sel_byte || (w_sel_addr[1:0] == 2'b00));
    assign w_load_ok  = ~w_sel_we & w_legal;

    assign req0_ready_o  = w_gnt0;
    assign req1_ready_o  = w_gnt1;
    assign mem_we_o      = w_any & w_sel_we & w_legal;
    assign mem_byte_op_o = w_sel_byte;
    assign mem_addr_o    = w_sel_addr;
    assign mem_wd_o      = w_sel_wd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (w_gnt1) begin
            r_wait_cnt <= '0;
        end else if (req1_valid_i && !w_force1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_err   <= 1'b0;
            r_rsp0_rd    <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_err   <= 1'b0;
            r_rsp1_rd    <= '0;
        end else begin
            r_rsp0_valid <= w_gnt0;
            r_rsp0_err   <= w_gnt0 & ~w_legal;
            r_rsp0_rd    <= (w_gnt0 & w_load_ok) ? mem_rd_i : '0;
            r_rsp1_valid <= w_gnt1;
            r_rsp1_err   <= w_gnt1 & ~w_legal;
            r_rsp1_rd    <= (w_gnt1 & w_load_ok) ? mem_rd_i : '0;
        end
    end

    assign rsp0_valid_o   = r_rsp0_valid;
    assign rsp0_err_o     = r_rsp0_err;
    assign rsp0_rd_o      = r_rsp0_rd;
    assign rsp1_valid_o   = r_rsp1_valid;
    assign rsp1_err_o     = r_rsp1_err;
    assign rsp1_rd_o      = r_rsp1_rd;
    assign dbg_wait_cnt_o = r_wait_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of grant order, address legality and a reference byte memory.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    localparam int          DW    = 32;
    localparam int          MW    = 4;
    localparam int          WCW   = 3;
    localparam logic [31:0] START = 32'h10000;
    localparam logic [31:0] END_A = 32'h1FFFF;
    localparam int          MEMSZ = 65536;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_we, req0_byte;
    logic [DW-1:0] req0_addr, req0_wd;
    logic          rsp0_valid, rsp0_err;
    logic [DW-1:0] rsp0_rd;
    logic          req1_valid, req1_ready, req1_we, req1_byte;
    logic [DW-1:0] req1_addr, req1_wd;
    logic          rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp1_rd;
    logic          mem_we, mem_byte;
    logic [DW-1:0] mem_addr, mem_wd, mem_rd;
    logic [WCW-1:0] dbg_wait;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment memory (driven by the DUT) and the model's own view of memory.
    logic [7:0] env_mem [MEMSZ];
    logic [7:0] ref_mem [MEMSZ];
    int         env_idx;

    // Model state and expectations.
    int          ref_wait;
    int          exp_gnt;
    int          exp_dbg;
    logic        exp_mem_we, exp_byte;
    logic [31:0] exp_addr, exp_wd;
    logic [DW:0] exp_q0 [$];
    logic [DW:0] exp_q1 [$];
    logic        exp0_v, exp0_err, exp1_v, exp1_err;
    logic [31:0] exp0_rd, exp1_rd;

    data_mem_arbiter #(
        .DATA_WIDTH(DW), .START_ADDRESS(START), .END_ADDRESS(END_A), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
        .req0_byte_i(req0_byte), .req0_addr_i(req0_addr), .req0_wd_i(req0_wd),
        .rsp0_valid_o(rsp0_valid), .rsp0_rd_o(rsp0_rd), .rsp0_err_o(rsp0_err),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
        .req1_byte_i(req1_byte), .req1_addr_i(req1_addr), .req1_wd_i(req1_wd),
        .rsp1_valid_o(rsp1_valid), .rsp1_rd_o(rsp1_rd), .rsp1_err_o(rsp1_err),
        .mem_we_o(mem_we), .mem_byte_op_o(mem_byte), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .dbg_wait_cnt_o(dbg_wait)
    );

    always #5 clk = ~clk;

    // Combinational read port; out-of-window reads return a non-zero pattern.
    always_comb begin
        env_idx = int'(mem_addr - START);
        mem_rd  = 32'h0BAD_F00D;
        if (mem_addr >= START && mem_addr <= END_A) begin
            if (mem_byte) mem_rd = {24'h0, env_mem[env_idx]};
            else if (mem_addr <= END_A - 32'd3)
                mem_rd = {env_mem[env_idx+3], env_mem[env_idx+2], env_mem[env_idx+1], env_mem[env_idx]};
        end
    end

    function automatic bit addr_ok(input logic is_byte, input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        if (is_byte) return (a >= longint'(START)) && (a <= longint'(END_A));
        return (a % 4 == 0) && (a >= longint'(START)) && (a + 3 <= longint'(END_A));
    endfunction

    function automatic logic [31:0] ref_load(input logic is_byte, input logic [31:0] addr);
        int i;
        i = int'(addr - START);
        if (is_byte) return {24'h0, ref_mem[i]};
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    // Predicts this cycle's grant and memory port, queues the response, advances model state.
    task automatic model_step();
        logic        s_we, s_byte;
        logic [31:0] s_addr, s_wd, rd;
        bit          ok;
        int          i;
        exp_dbg = ref_wait;
        if (!rst_n)                       exp_gnt = -1;
        else if (req0_valid && req1_valid) exp_gnt = (ref_wait == MW) ? 1 : 0;
        else if (req0_valid)              exp_gnt = 0;
        else if (req1_valid)              exp_gnt = 1;
        else                              exp_gnt = -1;
        s_we = 1'b0; s_byte = 1'b0; s_addr = '0; s_wd = '0;
        if (exp_gnt == 0) begin s_we = req0_we; s_byte = req0_byte; s_addr = req0_addr; s_wd = req0_wd; end
        if (exp_gnt == 1) begin s_we = req1_we; s_byte = req1_byte; s_addr = req1_addr; s_wd = req1_wd; end
        ok = addr_ok(s_byte, s_addr);
        exp_mem_we = (exp_gnt >= 0) && s_we && ok;
        exp_addr = s_addr; exp_wd = s_wd; exp_byte = s_byte;
        if (exp_gnt >= 0) begin
            rd = (!s_we && ok) ? ref_load(s_byte, s_addr) : 32'h0;
            if (s_we && ok) begin
                i = int'(s_addr - START);
                ref_mem[i] = s_wd[7:0];
                if (!s_byte) begin
                    ref_mem[i+1] = s_wd[15:8]; ref_mem[i+2] = s_wd[23:16]; ref_mem[i+3] = s_wd[31:24];
                end
            end
            if (exp_gnt == 0) exp_q0.push_back({~ok, rd});
            else              exp_q1.push_back({~ok, rd});
        end
        if (rst_n) begin
            if (exp_gnt == 1)                     ref_wait = 0;
            else if (req1_valid && ref_wait < MW) ref_wait = ref_wait + 1;
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic b0, input logic [31:0] a0,
                         input logic [31:0] wd0, input logic v1, input logic we1, input logic b1,
                         input logic [31:0] a1, input logic [31:0] wd1);
        @(negedge clk);
        req0_valid = v0; req0_we = we0; req0_byte = b0; req0_addr = a0; req0_wd = wd0;
        req1_valid = v1; req1_we = we1; req1_byte = b1; req1_addr = a1; req1_wd = wd1;
        #2;
        model_step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    // Crosses a rising edge, applies the DUT's write to the environment memory, pops expectations.
    task automatic tick();
        logic        we_s, byte_s;
        logic [31:0] a_s, wd_s;
        logic [DW:0] e;
        int          ix;
        we_s = mem_we; byte_s = mem_byte; a_s = mem_addr; wd_s = mem_wd;
        @(posedge clk);
        #1;
        if (we_s && a_s >= START && a_s <= END_A) begin
            ix = int'(a_s - START);
            if (byte_s) env_mem[ix] = wd_s[7:0];
            else if (a_s <= END_A - 32'd3) begin
                env_mem[ix] = wd_s[7:0]; env_mem[ix+1] = wd_s[15:8];
                env_mem[ix+2] = wd_s[23:16]; env_mem[ix+3] = wd_s[31:24];
            end
        end
        exp0_v = 1'b0; exp0_err = 1'b0; exp0_rd = '0;
        exp1_v = 1'b0; exp1_err = 1'b0; exp1_rd = '0;
        if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); exp0_v = 1'b1; exp0_err = e[DW]; exp0_rd = e[DW-1:0]; end
        if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); exp1_v = 1'b1; exp1_err = e[DW]; exp1_rd = e[DW-1:0]; end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] picks [5];
        picks = '{START - 32'd1, START - 32'd4, END_A + 32'd1, 32'h0, 32'hFFFF_FFFC};
        case ($urandom_range(0, 5))
            0:       return START + 32'(4 * $urandom_range(0, 7));
            1:       return START + 32'($urandom_range(0, 31));
            2:       return END_A - 32'd3 - 32'(4 * $urandom_range(0, 3));
            3:       return END_A - 32'($urandom_range(0, 7));
            4:       return picks[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_byte = 1'b0; req0_addr = START; req0_wd = 32'h1111_1111;
        req1_valid = 1'b1; req1_we = 1'b1; req1_byte = 1'b0; req1_addr = START; req1_wd = 32'h2222_2222;
        #2;
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b%b expected 00", req0_ready, req1_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
        @(posedge clk); #1;
        n_checks++; if ({rsp0_valid, rsp0_err, rsp0_rd, rsp1_valid, rsp1_err, rsp1_rd} !== '0) begin n_fail++; $display("FAIL reset rsp: got v%b e%b %h / v%b e%b %h expected all 0", rsp0_valid, rsp0_err, rsp0_rd, rsp1_valid, rsp1_err, rsp1_rd); end
        n_checks++; if (dbg_wait !== 3'd0) begin n_fail++; $display("FAIL reset wait_cnt: got %0d expected 0", dbg_wait); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        ref_wait = 0;
    endtask

    task automatic test_word_load();
        drive(1, 0, 0, START, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        n_checks++; if (req0_ready !== 1'b1 || mem_addr !== START || mem_we !== 1'b0) begin n_fail++; $display("FAIL word_load port: got rdy%b addr %h we%b expected rdy1 addr %h we0", req0_ready, mem_addr, mem_we, START); end
        tick();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rd !== 32'hDEADBEEF || rsp0_err !== 1'b0) begin n_fail++; $display("FAIL word_load rsp: got v%b %h e%b expected v1 deadbeef e0", rsp0_valid, rsp0_rd, rsp0_err); end
        idle(); tick();
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL word_load idle valid: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_fairness();
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 0, START + 32'd8, 32'h0, 1, 0, 0, START + 32'd12, 32'h0);
            n_checks++; if (req1_ready !== (c % 5 == 4) || req0_ready !== (c % 5 != 4)) begin n_fail++; $display("FAIL fairness grant c%0d: got %b%b expected req1=%0d", c, req0_ready, req1_ready, c % 5 == 4); end
            n_checks++; if (dbg_wait !== 3'(c % 5)) begin n_fail++; $display("FAIL fairness wait_cnt c%0d: got %0d expected %0d", c, dbg_wait, c % 5); end
            tick();
            n_checks++; if (rsp1_valid !== (c % 5 == 4) || rsp0_valid !== (c % 5 != 4)) begin n_fail++; $display("FAIL fairness rsp c%0d: got %b%b", c, rsp0_valid, rsp1_valid); end
        end
        idle(); tick();
    endtask

    task automatic test_byte_store_load();
        int we_cnt = 0;
        drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, END_A, 32'hFFFF_FFA5);
        we_cnt += int'(mem_we);
        tick();
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b0 || rsp1_rd !== 32'h0) begin n_fail++; $display("FAIL byte_store rsp: got v%b e%b %h expected v1 e0 0", rsp1_valid, rsp1_err, rsp1_rd); end
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 1, END_A, 32'h0);
        we_cnt += int'(mem_we);
        tick();
        n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL byte_store we count: got %0d expected 1", we_cnt); end
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_rd !== 32'h0000_00A5 || rsp1_err !== 1'b0) begin n_fail++; $display("FAIL byte_load rsp: got v%b %h e%b expected v1 000000a5 e0", rsp1_valid, rsp1_rd, rsp1_err); end
        idle(); tick();
    endtask

    task automatic test_illegal();
        drive(1, 1, 0, START + 32'd2, 32'h1234_5678, 0, 0, 0, 32'h0, 32'h0);
        n_checks++; if (req0_ready !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL illegal misaligned port: got rdy%b we%b expected rdy1 we0", req0_ready, mem_we); end
        tick();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rd !== 32'h0) begin n_fail++; $display("FAIL illegal misaligned rsp: got v%b e%b %h expected v1 e1 0", rsp0_valid, rsp0_err, rsp0_rd); end
        drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h0000_FFFF, 32'h5A);
        n_checks++; if (req1_ready !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL illegal low port: got rdy%b we%b expected rdy1 we0", req1_ready, mem_we); end
        tick();
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_rd !== 32'h0) begin n_fail++; $display("FAIL illegal low rsp: got v%b e%b %h expected v1 e1 0", rsp1_valid, rsp1_err, rsp1_rd); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (env_mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL illegal mem[%0d]: got %h expected %h", i, env_mem[i], ref_mem[i]); end
        end
        idle(); tick();
    endtask

    task automatic test_boundary();
        drive(1, 0, 0, END_A - 32'd3, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        n_checks++; if (rsp0_err !== 1'b0 || rsp0_rd !== exp0_rd) begin n_fail++; $display("FAIL boundary 1fffc: got e%b %h expected e0 %h", rsp0_err, rsp0_rd, exp0_rd); end
        drive(1, 0, 0, END_A - 32'd2, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rd !== 32'h0) begin n_fail++; $display("FAIL boundary 1fffd: got v%b e%b %h expected v1 e1 0", rsp0_valid, rsp0_err, rsp0_rd); end
        drive(1, 0, 1, START - 32'd1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        n_checks++; if (rsp0_err !== 1'b1 || rsp0_rd !== 32'h0) begin n_fail++; $display("FAIL boundary ffff byte: got e%b %h expected e1 0", rsp0_err, rsp0_rd); end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, k[0], START + 32'(4 * k + 1 - int'(!k[0])), 32'h0, 0, 0, 0, 32'h0, 32'h0);
            tick();
            n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rd !== exp0_rd || rsp0_err !== exp0_err) begin n_fail++; $display("FAIL back_to_back k%0d: got v%b %h e%b expected v1 %h e%b", k, rsp0_valid, rsp0_rd, rsp0_err, exp0_rd, exp0_err); end
        end
        idle(); tick();
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back tail valid: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), rand_addr(), $urandom,
                  ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), rand_addr(), $urandom);
            n_checks++; if (req0_ready !== (exp_gnt == 0) || req1_ready !== (exp_gnt == 1)) begin n_fail++; $display("FAIL random grant c%0d: got %b%b expected gnt %0d", c, req0_ready, req1_ready, exp_gnt); end
            n_checks++; if (mem_we !== exp_mem_we || mem_byte !== exp_byte || mem_addr !== exp_addr || mem_wd !== exp_wd) begin n_fail++; $display("FAIL random mem port c%0d: got we%b b%b %h %h expected we%b b%b %h %h", c, mem_we, mem_byte, mem_addr, mem_wd, exp_mem_we, exp_byte, exp_addr, exp_wd); end
            n_checks++; if (dbg_wait !== 3'(exp_dbg)) begin n_fail++; $display("FAIL random wait_cnt c%0d: got %0d expected %0d", c, dbg_wait, exp_dbg); end
            tick();
            n_checks++; if (rsp0_valid !== exp0_v || rsp0_err !== exp0_err || rsp0_rd !== exp0_rd) begin n_fail++; $display("FAIL random rsp0 c%0d: got v%b e%b %h expected v%b e%b %h", c, rsp0_valid, rsp0_err, rsp0_rd, exp0_v, exp0_err, exp0_rd); end
            n_checks++; if (rsp1_valid !== exp1_v || rsp1_err !== exp1_err || rsp1_rd !== exp1_rd) begin n_fail++; $display("FAIL random rsp1 c%0d: got v%b e%b %h expected v%b e%b %h", c, rsp1_valid, rsp1_err, rsp1_rd, exp1_v, exp1_err, exp1_rd); end
        end
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, START, 32'h0, 1, 0, 0, START + 32'd4, 32'h0);
            tick();
        end
        n_checks++; if (rsp0_valid !== 1'b1 || dbg_wait === 3'd0) begin n_fail++; $display("FAIL reset_mid setup: got v%b wait %0d expected v1 wait>0", rsp0_valid, dbg_wait); end
        drive(1, 0, 0, START, 32'h0, 1, 0, 0, START + 32'd4, 32'h0);
        rst_n = 1'b0;
        #1;
        exp_q0.delete(); exp_q1.delete(); ref_wait = 0;
        n_checks++; if ({rsp0_valid, rsp0_err, rsp0_rd, rsp1_valid, rsp1_err, rsp1_rd} !== '0) begin n_fail++; $display("FAIL reset_mid rsp: got v%b %h / v%b %h expected all 0", rsp0_valid, rsp0_rd, rsp1_valid, rsp1_rd); end
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_we !== 1'b0 || dbg_wait !== 3'd0) begin n_fail++; $display("FAIL reset_mid comb: got rdy%b%b we%b wait %0d expected 0", req0_ready, req1_ready, mem_we, dbg_wait); end
        @(posedge clk); #1;
        n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid discard: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        model_step();
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid first grant: got %b%b expected 10", req0_ready, req1_ready); end
        tick();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_rd !== exp0_rd || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid first rsp: got v%b %h v%b expected v1 %h v0", rsp0_valid, rsp0_rd, rsp1_valid, exp0_rd); end
        idle(); tick();
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) begin
            env_mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        env_mem[0] = 8'hEF; env_mem[1] = 8'hBE; env_mem[2] = 8'hAD; env_mem[3] = 8'hDE;
        ref_mem[0] = 8'hEF; ref_mem[1] = 8'hBE; ref_mem[2] = 8'hAD; ref_mem[3] = 8'hDE;
        ref_wait = 0;
        test_reset();
        test_word_load();
        test_fairness();
        test_byte_store_load();
        test_illegal();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
